// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: sized, lane-aligned accesses over a req/ack data-memory port.
// Optional macro MISALIGN_TRAP_EN: misaligned accesses trap (misalign_o) instead of being force-aligned.
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              mem_to_reg_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   result_o,
  output logic              result_valid_o,
  output logic              stall_o,
  output logic              bus_err_o,
`ifdef MISALIGN_TRAP_EN
  output logic              misalign_o,
`endif
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [XLEN/8-1:0] dmem_be_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [XLEN-1:0]   dmem_rdata_i
);
  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  function automatic logic [OFFW-1:0] low_mask(input logic [1:0] sz);
    logic [2:0] m;
    case (sz)
      2'd0:    m = 3'd0;
      2'd1:    m = 3'd1;
      2'd2:    m = 3'd3;
      default: m = 3'd7;
    endcase
    return OFFW'(m);
  endfunction

  function automatic logic [BYTES-1:0] size_be(input logic [1:0] sz, input logic [OFFW-1:0] off);
    logic [7:0] m;
    case (sz)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return BYTES'(m) << off;
  endfunction

  function automatic logic [XLEN-1:0] repl_wdata(input logic [1:0] sz, input logic [XLEN-1:0] w);
    case (sz)
      2'd0:    return {BYTES{w[7:0]}};
      2'd1:    return {(BYTES/2){w[15:0]}};
      2'd2:    return {(BYTES/4){w[31:0]}};
      default: return w;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend by size.
  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] rd,
                                               input logic [OFFW-1:0] off,
                                               input logic [2:0] f3);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = rd >> {off, 3'b000};
    case (f3[1:0])
      2'd0:    res = f3[2] ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]));
      2'd1:    res = f3[2] ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]));
      2'd2:    res = f3[2] ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]));
      default: res = sh;
    endcase
    return res;
  endfunction

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [BYTES-1:0]  be_q, be_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [2:0]        f3_q, f3_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic              ld_q, ld_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  logic [OFFW-1:0]   lmask;
  logic [OFFW-1:0]   eff_off;
  logic              memop;
  logic              legal;
  logic              issue;
  logic              trap;

  always_comb begin
    lmask   = low_mask(funct3_i[1:0]);
    eff_off = addr_i[OFFW-1:0] & ~lmask;
    memop   = valid_i & (mem_read_i | mem_write_i);
    legal   = (funct3_i != 3'b111)
            && !(funct3_i[1:0] == 2'b11 && XLEN != 64)
            && !(funct3_i == 3'b110 && XLEN != 64)
            && !(mem_write_i && funct3_i[2]);
`ifdef MISALIGN_TRAP_EN
    trap    = memop & legal & (|(addr_i[OFFW-1:0] & lmask));
`else
    trap    = 1'b0;
`endif
    issue   = memop & legal & ~trap;
  end

  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    we_d           = we_q;
    be_d           = be_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    f3_d           = f3_q;
    off_d          = off_q;
    ld_d           = ld_q;
    rdata_d        = rdata_q;
    stall_o        = 1'b0;
    result_o       = '0;
    result_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          stall_o = 1'b1;
          state_d = WAIT;
          req_d   = 1'b1;
          we_d    = mem_write_i;
          be_d    = size_be(funct3_i[1:0], eff_off);
          addr_d  = {addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
          wdata_d = repl_wdata(funct3_i[1:0], wdata_i);
          cnt_d   = '0;
          err_d   = 1'b0;
          f3_d    = funct3_i;
          off_d   = eff_off;
          ld_d    = ~mem_write_i & mem_to_reg_i;
        end else begin
          result_valid_o = valid_i;
          result_o       = ((memop & ~legal) | trap) ? '0 : addr_i;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (dmem_ack_i) begin
          rdata_d = fmt_load(dmem_rdata_i, off_q, f3_q);
          state_d = DONE;
          req_d   = 1'b0;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
          req_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        result_valid_o = 1'b1;
        result_o       = err_q ? '0 : (ld_q ? rdata_q : addr_i);
        state_d        = IDLE;
        err_d          = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Hold every combinational output low while reset is asserted.
    if (!rst_n) begin
      stall_o        = 1'b0;
      result_o       = '0;
      result_valid_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    f3_q    <= f3_d;
    off_q   <= off_d;
    ld_q    <= ld_d;
    rdata_q <= rdata_d;
  end

  assign bus_err_o    = (state_q == DONE) && err_q;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_be_o    = be_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign_o   = trap & rst_n & (state_q == IDLE);
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (XLEN=32, TIMEOUT=4) with a transaction-level expectation model.
module tb_mem_access_unit;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, valid_i, mem_read_i, mem_write_i, mem_to_reg_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i, result_o, dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic        result_valid_o, stall_o, bus_err_o, dmem_req_o, dmem_we_o, dmem_ack_i;
  logic [3:0]  dmem_be_o;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  mem_access_unit #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .result_o(result_o),
    .result_valid_o(result_valid_o), .stall_o(stall_o), .bus_err_o(bus_err_o),
`ifdef MISALIGN_TRAP_EN
    .misalign_o(misalign_o),
`endif
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i)
  );

  int vectors = 0;
  int miscompares = 0;

  logic        chk_en = 1'b0;
  logic        e_stall, e_rv, e_err, e_req, e_we, e_mis;
  logic [31:0] e_result, e_addr, e_wdata;
  logic [3:0]  e_be;

  int          cap_stalls;
  logic [31:0] cap_result, cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we, cap_err, cap_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    e_stall = 1'b0; e_rv = 1'b0; e_err = 1'b0; e_req = 1'b0; e_we = 1'b0; e_mis = 1'b0;
    e_result = '0; e_addr = '0; e_wdata = '0; e_be = '0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_o", 32'(stall_o), 32'(e_stall));
      chk("result_valid_o", 32'(result_valid_o), 32'(e_rv));
      chk("bus_err_o", 32'(bus_err_o), 32'(e_err));
      chk("dmem_req_o", 32'(dmem_req_o), 32'(e_req));
      if (e_req) begin
        chk("dmem_we_o", 32'(dmem_we_o), 32'(e_we));
        chk("dmem_be_o", 32'(dmem_be_o), 32'(e_be));
        chk("dmem_addr_o", dmem_addr_o, e_addr);
        chk("dmem_wdata_o", dmem_wdata_o, e_wdata);
      end
      if (e_rv) chk("result_o", result_o, e_result);
`ifdef MISALIGN_TRAP_EN
      chk("misalign_o", 32'(misalign_o), 32'(e_mis));
`endif
    end
  end

  // One instruction through the MEM stage; ack_at = WAIT cycle carrying ack, 0 = never.
  task automatic run_txn(input logic rd, input logic wr, input logic m2r, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int ack_at, input logic [31:0] rdata);
    int size, lane, nwait;
    logic legal, mis, issued, tmo;
    logic [31:0] eaddr, wd, load_val;
    logic [3:0]  be;
    logic [63:0] mask, v;
    size  = 1 << f3[1:0];
    legal = (f3 != 3'b111) && (f3[1:0] != 2'b11) && (f3 != 3'b110) && !(wr && f3[2]);
    mis   = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis   = (addr % 32'(size)) != 0;
`endif
    issued = (rd || wr) && legal && !mis;
    eaddr  = addr & ~32'(size - 1);
    lane   = int'(eaddr[1:0]);
    be     = 4'(((1 << size) - 1) << lane);
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdata[8*(i % size) +: 8];
    mask = (64'd1 << (8 * size)) - 64'd1;
    v    = (64'(rdata) >> (8 * lane)) & mask;
    if (!f3[2] && v[8*size-1]) v = v | ~mask;
    load_val = v[31:0];
    tmo   = (ack_at < 1) || (ack_at > TIMEOUT);
    nwait = tmo ? TIMEOUT : ack_at;

    @(posedge clk); #1;
    valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; mem_to_reg_i = m2r;
    funct3_i = f3; addr_i = addr; wdata_i = wdata; dmem_ack_i = 1'b0;
    set_idle();
    e_stall  = issued;
    e_rv     = !issued;
    e_result = ((rd || wr) && (!legal || mis)) ? 32'h0 : addr;
    e_mis    = (rd || wr) && legal && mis;
    @(negedge clk);
    cap_stalls = int'(stall_o);
    cap_result = result_o;
    cap_err    = bus_err_o;
`ifdef MISALIGN_TRAP_EN
    cap_mis    = misalign_o;
`else
    cap_mis    = 1'b0;
`endif
    if (issued) begin
      for (int c = 1; c <= nwait; c++) begin
        @(posedge clk); #1;
        dmem_ack_i = (c == ack_at); dmem_rdata_i = rdata;
        set_idle();
        e_stall = 1'b1; e_req = 1'b1; e_we = wr; e_be = be;
        e_addr = eaddr & 32'hFFFF_FFFC; e_wdata = wd;
        @(negedge clk);
        cap_stalls += int'(stall_o);
        cap_be = dmem_be_o; cap_wdata = dmem_wdata_o; cap_we = dmem_we_o; cap_addr = dmem_addr_o;
      end
      @(posedge clk); #1;
      dmem_ack_i = 1'b0;
      set_idle();
      e_rv     = 1'b1;
      e_err    = tmo;
      e_result = tmo ? 32'h0 : ((rd && !wr && m2r) ? load_val : addr);
      @(negedge clk);
      cap_stalls += int'(stall_o);
      cap_result = result_o;
      cap_err    = bus_err_o;
    end
    @(posedge clk); #1;
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    set_idle();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected completion within time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; mem_to_reg_i = 1'b0;
    funct3_i = 3'b010; addr_i = '0; wdata_i = '0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    set_idle();
    cap_stalls = 0; cap_result = '0; cap_addr = '0; cap_wdata = '0; cap_be = '0;
    cap_we = 1'b0; cap_err = 1'b0; cap_mis = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset dmem_req_o", 32'(dmem_req_o), 32'h0);
    chk("reset stall_o", 32'(stall_o), 32'h0);
    chk("reset result_valid_o", 32'(result_valid_o), 32'h0);
    chk("reset bus_err_o", 32'(bus_err_o), 32'h0);
    chk("reset dmem_be_o", 32'(dmem_be_o), 32'h0);
    chk("reset dmem_addr_o", dmem_addr_o, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    run_txn(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF);
    chk("lw result", cap_result, 32'hDEAD_BEEF);
    chk("lw stall cycles", 32'(cap_stalls), 32'd4);
    chk("lw be", 32'(cap_be), 32'h0000_000F);

    run_txn(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0, 1, 32'h8012_3456);
    chk("lb sign", cap_result, 32'hFFFF_FF80);
    run_txn(1'b1, 1'b0, 1'b1, 3'b100, 32'h0000_0103, 32'h0, 2, 32'h8012_3456);
    chk("lbu zero", cap_result, 32'h0000_0080);

    run_txn(1'b0, 1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 2, 32'h0);
    chk("sh be", 32'(cap_be), 32'h0000_000C);
    chk("sh wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh we", 32'(cap_we), 32'h1);
    chk("sh result", cap_result, 32'h0000_0102);

    run_txn(1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0, 1, 32'h8001_7FFF);
    chk("lh sign", cap_result, 32'hFFFF_8001);
    run_txn(1'b1, 1'b0, 1'b1, 3'b101, 32'h0000_0100, 32'h0, 2, 32'h1234_F00D);
    run_txn(1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0000_00A5, 1, 32'h0);
    chk("sb be", 32'(cap_be), 32'h0000_0002);

    run_txn(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'h0, 0, 32'h5555_5555);
    chk("timeout result", cap_result, 32'h0);
    chk("timeout bus_err", 32'(cap_err), 32'h1);
    chk("timeout stall cycles", 32'(cap_stalls), 32'd5);
    run_txn(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0204, 32'h0, 4, 32'h1122_3344);
    chk("ack on last cycle", cap_result, 32'h1122_3344);

    run_txn(1'b1, 1'b0, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 1, 32'h9999_9999);
    run_txn(1'b0, 1'b0, 1'b0, 3'b010, 32'hCAFE_0000, 32'h0, 0, 32'h0);
    chk("alu passthrough", cap_result, 32'hCAFE_0000);
    run_txn(1'b1, 1'b0, 1'b1, 3'b011, 32'h0000_0400, 32'h0, 1, 32'h0);
    chk("illegal ld stall", 32'(cap_stalls), 32'd0);
    run_txn(1'b0, 1'b1, 1'b0, 3'b100, 32'h0000_0404, 32'h0, 1, 32'h0);

    run_txn(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'h0, 1, 32'h0BAD_F00D);
`ifdef MISALIGN_TRAP_EN
    chk("misalign pulse", 32'(cap_mis), 32'h1);
    chk("misalign stall", 32'(cap_stalls), 32'd0);
`else
    chk("forced align addr", cap_addr, 32'h0000_0100);
    chk("forced align result", cap_result, 32'h0BAD_F00D);
`endif

    // Reset while WAIT is outstanding, then a late ack that must be ignored.
    chk_en = 1'b0;
    @(posedge clk); #1;
    valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; mem_to_reg_i = 1'b1;
    funct3_i = 3'b010; addr_i = 32'h0000_0500;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait req before reset", 32'(dmem_req_o), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0; valid_i = 1'b0; mem_read_i = 1'b0;
    @(negedge clk);
    chk("reset cycle stall", 32'(stall_o), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; dmem_ack_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
    @(negedge clk);
    chk("late ack req", 32'(dmem_req_o), 32'h0);
    chk("late ack valid", 32'(result_valid_o), 32'h0);
    chk("late ack stall", 32'(stall_o), 32'h0);
    @(posedge clk); #1;
    dmem_ack_i = 1'b0;
    @(negedge clk);
    chk("after late ack valid", 32'(result_valid_o), 32'h0);
    chk("after late ack req", 32'(dmem_req_o), 32'h0);
    set_idle();
    chk_en = 1'b1;

    run_txn(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0600, 32'h0, 2, 32'h0102_0304);
    chk("post reset lw", cap_result, 32'h0102_0304);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
